network_exit_sink: RTL and testbench

Synthesizable receiver for one exit gate of the network core. It accepts single-word packets ejected by a border router, checks the destination gate field against its own address and buffers accepted packets in a small FIFO. It drains that FIFO to a local consumer over valid/ready, returns flow-control credits to the router, and keeps reception statistics. It is the hardware counterpart of the bench-side injectors: one instance sits on each x-/x+ exit gate.

---
 rtl/network_exit_sink.sv | 159 +++++++++++++++
 tb/tb_network_exit_sink.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/network_exit_sink.sv
// Exit-gate receiver: checks the destination against (GATE_X, GATE_Y), buffers packets in a FIFO,
// returns credits and keeps statistics. Define NETWORK_EXIT_SINK_DROP_EN to discard misrouted packets.
module network_exit_sink #(
    parameter int CHANNEL_WIDTH = 64,
    parameter int X_ADDR        = 3,
    parameter int Y_ADDR        = 3,
    parameter int GATE_X        = 1,
    parameter int GATE_Y        = 1,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [CHANNEL_WIDTH-1:0] channel_din,
    input  logic                     done_strobe_din,
    output logic                     credit_out_dout,
    output logic [CHANNEL_WIDTH-1:0] pkt_dout,
    output logic                     pkt_valid_dout,
    input  logic                     pkt_ready_din,
    output logic [31:0]              packet_count_dout,
    output logic [15:0]              misroute_count_dout,
    output logic [31:0]              last_serial_dout,
    output logic                     overflow_dout
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0]  FULL_OCC = CNT_W'(FIFO_DEPTH);
    localparam logic [X_ADDR-1:0] MY_X     = X_ADDR'(GATE_X);
    localparam logic [Y_ADDR-1:0] MY_Y     = Y_ADDR'(GATE_Y);

    logic [CHANNEL_WIDTH-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr_r;
    logic [PTR_W-1:0]         rd_ptr_r;
    logic [CNT_W-1:0]         occ_r;
    logic [CNT_W-1:0]         pending_r;
    logic                     credit_r;
    logic [31:0]              packet_count_r;
    logic [15:0]              misroute_count_r;
    logic [31:0]              last_serial_r;
    logic                     overflow_r;

    logic [X_ADDR-1:0] dest_x_s;
    logic [Y_ADDR-1:0] dest_y_s;
    logic              misroute_s;
    logic              drop_s;
    logic              valid_s;
    logic              full_s;
    logic              pop_s;
    logic              push_s;
    logic              reject_s;
    logic              credit_next_s;
    logic [CNT_W-1:0]  occ_next_s;
    logic [CNT_W-1:0]  credit_sum_s;
    logic [CNT_W-1:0]  pending_next_s;
    logic [31:0]       packet_count_next_s;
    logic [15:0]       misroute_count_next_s;

    assign dest_x_s   = channel_din[CHANNEL_WIDTH-1 -: X_ADDR];
    assign dest_y_s   = channel_din[CHANNEL_WIDTH-1-X_ADDR -: Y_ADDR];
    assign misroute_s = (dest_x_s != MY_X) || (dest_y_s != MY_Y);

`ifdef NETWORK_EXIT_SINK_DROP_EN
    assign drop_s = done_strobe_din & misroute_s;
`else
    assign drop_s = 1'b0;
`endif

    // Push/pop qualification, occupancy, pending credits and saturating statistics
    always_comb begin
        valid_s  = (occ_r != CNT_ZERO);
        full_s   = (occ_r == FULL_OCC);
        pop_s    = valid_s & pkt_ready_din;
        push_s   = done_strobe_din & ~drop_s & (~full_s | pop_s);
        reject_s = done_strobe_din & ~drop_s & full_s & ~pop_s;

        occ_next_s = occ_r;
        if (push_s && !pop_s) begin
            occ_next_s = occ_r + CNT_ONE;
        end else if (pop_s && !push_s) begin
            occ_next_s = occ_r - CNT_ONE;
        end else begin
            occ_next_s = occ_r;
        end

        // a pop and a drop in the same cycle both free a slot, so the sum can step by two
        credit_sum_s = pending_r + CNT_W'(pop_s) + CNT_W'(drop_s);
        if (credit_sum_s != CNT_ZERO) begin
            credit_next_s  = 1'b1;
            pending_next_s = credit_sum_s - CNT_ONE;
        end else begin
            credit_next_s  = 1'b0;
            pending_next_s = credit_sum_s;
        end

        packet_count_next_s = packet_count_r;
        if (done_strobe_din && (packet_count_r != 32'hFFFF_FFFF)) begin
            packet_count_next_s = packet_count_r + 32'd1;
        end else begin
            packet_count_next_s = packet_count_r;
        end

        misroute_count_next_s = misroute_count_r;
        if (done_strobe_din && misroute_s && (misroute_count_r != 16'hFFFF)) begin
            misroute_count_next_s = misroute_count_r + 16'd1;
        end else begin
            misroute_count_next_s = misroute_count_r;
        end
    end

    // Control, credit and statistics registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r         <= '0;
            rd_ptr_r         <= '0;
            occ_r            <= '0;
            pending_r        <= '0;
            credit_r         <= 1'b0;
            packet_count_r   <= 32'd0;
            misroute_count_r <= 16'd0;
            last_serial_r    <= 32'd0;
            overflow_r       <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            occ_r            <= occ_next_s;
            pending_r        <= pending_next_s;
            credit_r         <= credit_next_s;
            packet_count_r   <= packet_count_next_s;
            misroute_count_r <= misroute_count_next_s;
            if (done_strobe_din) begin
                last_serial_r <= channel_din[31:0];
            end
            if (reject_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Packet storage; stale words are unreachable once the pointers are cleared
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= channel_din;
        end
    end

    assign pkt_valid_dout      = valid_s;
    assign pkt_dout            = valid_s ? mem_r[rd_ptr_r] : '0;
    assign credit_out_dout     = credit_r;
    assign packet_count_dout   = packet_count_r;
    assign misroute_count_dout = misroute_count_r;
    assign last_serial_dout    = last_serial_r;
    assign overflow_dout       = overflow_r;
endmodule

// File: tb/tb_network_exit_sink.sv
// Bench for network_exit_sink: directed scenarios plus credit-respecting random traffic,
// all checked against a queue-based reference model.
`timescale 1ns/1ps
module tb_network_exit_sink;
    localparam int D = 4;
`ifdef NETWORK_EXIT_SINK_DROP_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        strobe = 1'b0;
    logic        ready = 1'b0;
    logic [63:0] din = 64'd0;
    logic        credit_out;
    logic [63:0] pkt;
    logic        pkt_valid;
    logic [31:0] packet_count;
    logic [15:0] misroute_count;
    logic [31:0] last_serial;
    logic        overflow;

    network_exit_sink dut (
        .clk(clk), .reset(reset), .channel_din(din), .done_strobe_din(strobe),
        .credit_out_dout(credit_out), .pkt_dout(pkt), .pkt_valid_dout(pkt_valid),
        .pkt_ready_din(ready), .packet_count_dout(packet_count),
        .misroute_count_dout(misroute_count), .last_serial_dout(last_serial),
        .overflow_dout(overflow)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // reference model
    logic [63:0] q[$];
    logic [31:0] m_pkt = 32'd0;
    logic [31:0] m_serial = 32'd0;
    logic [15:0] m_mis = 16'd0;
    logic        m_ovf = 1'b0;
    int          owed = 0;
    int          credits_seen = 0;
    int          rc = D;

    function automatic logic [63:0] mk(input logic [2:0] x, input logic [2:0] y, input logic [31:0] s);
        logic [25:0] filler;
        filler = 26'($urandom);
        return {x, y, filler, s};
    endfunction

    // one clock: drive at negedge, update model at posedge, observe credit at next negedge
    task automatic cycle(input logic rst, input logic stb, input logic [63:0] d, input logic rdy);
        logic pop, mis, drop;
        reset = rst; strobe = stb; din = d; ready = rdy;
        @(posedge clk);
        if (rst) begin
            q.delete(); m_pkt = 32'd0; m_mis = 16'd0; m_serial = 32'd0; m_ovf = 1'b0; owed = 0;
        end else begin
            pop = (q.size() != 0) && rdy;
            if (pop) begin
                void'(q.pop_front());
                owed++;
            end
            if (stb) begin
                if (m_pkt != 32'hFFFF_FFFF) m_pkt++;
                m_serial = d[31:0];
                mis = (d[63:61] != 3'd1) || (d[60:58] != 3'd1);
                if (mis && (m_mis != 16'hFFFF)) m_mis++;
                drop = DROP && mis;
                if (drop) owed++;
                else if (q.size() < D) q.push_back(d);
                else m_ovf = 1'b1;
            end
        end
        @(negedge clk);
        if (credit_out === 1'b1) begin
            credits_seen++; owed--; rc++;
        end
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 64'd0, 1'b0);
        rc = D;
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b0, 64'd0, 1'b0);
        cycle(1'b1, 1'b1, mk(3'd1, 3'd1, 32'd99), 1'b1);
        rc = D;
        n_vec++; if (pkt_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0b want 0", pkt_valid); end
        n_vec++; if (pkt !== 64'd0) begin n_err++; $display("FAIL reset_pkt got %0h want 0", pkt); end
        n_vec++; if (credit_out !== 1'b0) begin n_err++; $display("FAIL reset_credit got %0b want 0", credit_out); end
        n_vec++; if (packet_count !== 32'd0) begin n_err++; $display("FAIL reset_pcount got %0d want 0", packet_count); end
        n_vec++; if (misroute_count !== 16'd0) begin n_err++; $display("FAIL reset_mis got %0d want 0", misroute_count); end
        n_vec++; if (last_serial !== 32'd0) begin n_err++; $display("FAIL reset_serial got %0d want 0", last_serial); end
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %0b want 0", overflow); end
    endtask

    task automatic test_in_order();
        int c0;
        do_reset();
        c0 = credits_seen;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, mk(3'd1, 3'd1, 32'(10 + i)), 1'b1);
            n_vec++; if (pkt_valid !== 1'b1) begin n_err++; $display("FAIL order_valid[%0d] got %0b want 1", i, pkt_valid); end
            n_vec++; if (pkt[31:0] !== 32'(10 + i)) begin n_err++; $display("FAIL order_serial[%0d] got %0d want %0d", i, pkt[31:0], 10 + i); end
            if (i > 0) begin
                n_vec++; if (credit_out !== 1'b1) begin n_err++; $display("FAIL order_credit[%0d] got %0b want 1", i, credit_out); end
            end
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 64'd0, 1'b1);
        n_vec++; if (credits_seen - c0 != 4) begin n_err++; $display("FAIL order_credits got %0d want 4", credits_seen - c0); end
        n_vec++; if (packet_count !== 32'd4) begin n_err++; $display("FAIL order_pcount got %0d want 4", packet_count); end
        n_vec++; if (last_serial !== 32'd13) begin n_err++; $display("FAIL order_serial got %0d want 13", last_serial); end
        n_vec++; if (pkt_valid !== 1'b0) begin n_err++; $display("FAIL order_empty got %0b want 0", pkt_valid); end
    endtask

    task automatic test_backpressure();
        int c0;
        do_reset();
        c0 = credits_seen;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, mk(3'd1, 3'd1, 32'(20 + i)), 1'b0);
            n_vec++; if (pkt_valid !== 1'b1 || pkt[31:0] !== 32'd20) begin n_err++; $display("FAIL bp_hold[%0d] got v=%0b s=%0d want v=1 s=20", i, pkt_valid, pkt[31:0]); end
        end
        cycle(1'b0, 1'b1, mk(3'd1, 3'd1, 32'd24), 1'b0);
        n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL bp_overflow got %0b want 1", overflow); end
        n_vec++; if (packet_count !== 32'd5) begin n_err++; $display("FAIL bp_pcount got %0d want 5", packet_count); end
        n_vec++; if (credits_seen != c0) begin n_err++; $display("FAIL bp_nocredit got %0d want 0", credits_seen - c0); end
        for (int i = 0; i < 4; i++) begin
            n_vec++; if (pkt_valid !== 1'b1 || pkt[31:0] !== 32'(20 + i)) begin n_err++; $display("FAIL bp_drain[%0d] got v=%0b s=%0d want v=1 s=%0d", i, pkt_valid, pkt[31:0], 20 + i); end
            cycle(1'b0, 1'b0, 64'd0, 1'b1);
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 64'd0, 1'b1);
        n_vec++; if (credits_seen - c0 != 4) begin n_err++; $display("FAIL bp_credits got %0d want 4", credits_seen - c0); end
        n_vec++; if (pkt_valid !== 1'b0) begin n_err++; $display("FAIL bp_empty got %0b want 0", pkt_valid); end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, mk(3'd1, 3'd1, 32'(30 + i)), 1'b0);
        cycle(1'b0, 1'b1, mk(3'd1, 3'd1, 32'd34), 1'b1);
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL fpp_overflow got %0b want 0", overflow); end
        n_vec++; if (credit_out !== 1'b1) begin n_err++; $display("FAIL fpp_credit got %0b want 1", credit_out); end
        for (int i = 0; i < 4; i++) begin
            n_vec++; if (pkt_valid !== 1'b1 || pkt[31:0] !== 32'(31 + i)) begin n_err++; $display("FAIL fpp_drain[%0d] got v=%0b s=%0d want v=1 s=%0d", i, pkt_valid, pkt[31:0], 31 + i); end
            cycle(1'b0, 1'b0, 64'd0, 1'b1);
        end
        n_vec++; if (pkt_valid !== 1'b0) begin n_err++; $display("FAIL fpp_empty got %0b want 0", pkt_valid); end
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 64'd0, 1'b1);
    endtask

    task automatic test_drop();
        int c0;
        do_reset();
        cycle(1'b0, 1'b1, mk(3'd1, 3'd1, 32'd40), 1'b0);
        c0 = credits_seen;
        cycle(1'b0, 1'b1, mk(3'd5, 3'd3, 32'd41), 1'b1);
        n_vec++; if (misroute_count !== 16'd1) begin n_err++; $display("FAIL drop_mis got %0d want 1", misroute_count); end
        n_vec++; if (credit_out !== 1'b1) begin n_err++; $display("FAIL drop_credit1 got %0b want 1", credit_out); end
        n_vec++; if (pkt_valid !== !DROP) begin n_err++; $display("FAIL drop_valid got %0b want %0b", pkt_valid, !DROP); end
        if (!DROP) begin
            n_vec++; if (pkt[31:0] !== 32'd41) begin n_err++; $display("FAIL drop_fwd got %0d want 41", pkt[31:0]); end
        end
        cycle(1'b0, 1'b0, 64'd0, 1'b1);
        n_vec++; if (credit_out !== 1'b1) begin n_err++; $display("FAIL drop_credit2 got %0b want 1", credit_out); end
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 64'd0, 1'b1);
        n_vec++; if (credits_seen - c0 != 2) begin n_err++; $display("FAIL drop_credits got %0d want 2", credits_seen - c0); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, mk(3'd1, 3'd1, 32'(50 + i)), 1'b0);
        cycle(1'b1, 1'b1, mk(3'd1, 3'd1, 32'd53), 1'b1);
        n_vec++; if (pkt_valid !== 1'b0) begin n_err++; $display("FAIL rmid_valid got %0b want 0", pkt_valid); end
        n_vec++; if (packet_count !== 32'd0) begin n_err++; $display("FAIL rmid_pcount got %0d want 0", packet_count); end
        n_vec++; if (credit_out !== 1'b0) begin n_err++; $display("FAIL rmid_credit got %0b want 0", credit_out); end
        cycle(1'b0, 1'b0, 64'd0, 1'b1);
        rc = D;
        n_vec++; if (credit_out !== 1'b0 || pkt_valid !== 1'b0) begin n_err++; $display("FAIL rmid_after got c=%0b v=%0b want 0 0", credit_out, pkt_valid); end
        n_vec++; if (packet_count !== 32'd0 || last_serial !== 32'd0) begin n_err++; $display("FAIL rmid_stats got %0d/%0d want 0/0", packet_count, last_serial); end
    endtask

    task automatic test_saturate();
        do_reset();
        force dut.packet_count_r = 32'hFFFF_FFFE;
        #1;
        release dut.packet_count_r;
        m_pkt = 32'hFFFF_FFFE;
        cycle(1'b0, 1'b1, mk(3'd1, 3'd1, 32'd60), 1'b1);
        n_vec++; if (packet_count !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL sat_reach got %0h want ffffffff", packet_count); end
        cycle(1'b0, 1'b1, mk(3'd1, 3'd1, 32'd61), 1'b1);
        n_vec++; if (packet_count !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL sat_hold got %0h want ffffffff", packet_count); end
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 64'd0, 1'b1);
    endtask

    task automatic test_random();
        logic        stb, rdy;
        logic [63:0] d;
        logic [63:0] head;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            stb = (rc > 0) && ($urandom_range(2) != 0);
            if (stb) rc--;
            if ($urandom_range(3) == 0) d = mk(3'($urandom), 3'($urandom), $urandom);
            else d = mk(3'd1, 3'd1, $urandom);
            rdy = 1'($urandom);
            cycle(1'b0, stb, d, rdy);
            head = (q.size() != 0) ? q[0] : 64'd0;
            n_vec++; if (pkt_valid !== (q.size() != 0)) begin n_err++; $display("FAIL rnd_valid[%0d] got %0b want %0b", n, pkt_valid, q.size() != 0); end
            n_vec++; if (pkt !== head) begin n_err++; $display("FAIL rnd_pkt[%0d] got %0h want %0h", n, pkt, head); end
            n_vec++; if (packet_count !== m_pkt || misroute_count !== m_mis) begin n_err++; $display("FAIL rnd_counts[%0d] got %0d/%0d want %0d/%0d", n, packet_count, misroute_count, m_pkt, m_mis); end
            n_vec++; if (last_serial !== m_serial || overflow !== m_ovf) begin n_err++; $display("FAIL rnd_stat[%0d] got %0d/%0b want %0d/%0b", n, last_serial, overflow, m_serial, m_ovf); end
            n_vec++; if (owed < 0) begin n_err++; $display("FAIL rnd_early_credit[%0d] got owed %0d want >=0", n, owed); end
        end
        for (int i = 0; i < 2 * D + 6; i++) cycle(1'b0, 1'b0, 64'd0, 1'b1);
        n_vec++; if (owed != 0 || rc != D) begin n_err++; $display("FAIL rnd_credit_balance got owed=%0d rc=%0d want 0/%0d", owed, rc, D); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_in_order();
        test_backpressure();
        test_full_push_pop();
        test_drop();
        test_reset_mid();
        test_saturate();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
